// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage redirect/stall arbiter with per-stage valid tracking and flush strobes.
// Optional statistics counters are enabled by defining REDIRECT_STATS_EN.
module fetch_redirect_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_redir,
    input  logic             EX1_redir,
    input  logic             EX2_redir,
    input  logic             hazard_stall,
    output logic [2:0]       PC_src,
    output logic             PC_write,
    output logic             IF_ID_flush,
    output logic             ID_EX1_flush,
    output logic             EX1_EX2_flush,
    output logic             ID_valid,
    output logic             EX1_valid,
    output logic             EX2_valid
`ifdef REDIRECT_STATS_EN
    ,
    output logic [CNT_W-1:0] redir_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [2:0] SRC_SEQ  = 3'd0;
    localparam logic [2:0] SRC_ID   = 3'd1;
    localparam logic [2:0] SRC_HOLD = 3'd2;
    localparam logic [2:0] SRC_EX1  = 3'd3;
    localparam logic [2:0] SRC_EX2  = 3'd4;

    typedef enum logic [2:0] {
        WIN_NONE,
        WIN_ID,
        WIN_STALL,
        WIN_EX1,
        WIN_EX2
    } winner_e;

    logic    vId_q, vEx1_q, vEx2_q;
    logic    vId_d, vEx1_d, vEx2_d;
    logic    effEx2, effEx1, effStall, effId;
    winner_e winner;

    // Requests from squashed (wrong-path) stages are masked off here.
    assign effEx2   = EX2_redir    & vEx2_q;
    assign effEx1   = EX1_redir    & vEx1_q;
    assign effStall = hazard_stall & vId_q;
    assign effId    = ID_redir     & vId_q;

    always_comb begin
        winner = WIN_NONE;
        if (effEx2)
            winner = WIN_EX2;
        else if (effEx1)
            winner = WIN_EX1;
        else if (effStall)
            winner = WIN_STALL;
        else if (effId)
            winner = WIN_ID;
    end

    always_comb begin
        PC_src        = SRC_SEQ;
        PC_write      = 1'b0;
        IF_ID_flush   = 1'b0;
        ID_EX1_flush  = 1'b0;
        EX1_EX2_flush = 1'b0;
        if (rst) begin
            PC_write = 1'b1;
            unique case (winner)
                WIN_EX2: begin
                    PC_src        = SRC_EX2;
                    IF_ID_flush   = 1'b1;
                    ID_EX1_flush  = 1'b1;
                    EX1_EX2_flush = 1'b1;
                end
                WIN_EX1: begin
                    PC_src       = SRC_EX1;
                    IF_ID_flush  = 1'b1;
                    ID_EX1_flush = 1'b1;
                end
                WIN_STALL: begin
                    PC_src       = SRC_HOLD;
                    PC_write     = 1'b0;
                    ID_EX1_flush = 1'b1;
                end
                WIN_ID: begin
                    PC_src      = SRC_ID;
                    IF_ID_flush = 1'b1;
                end
                default: PC_src = SRC_SEQ;
            endcase
        end
    end

    always_comb begin
        vId_d  = 1'b1;
        vEx1_d = vId_q;
        vEx2_d = vEx1_q;
        unique case (winner)
            WIN_EX2: begin
                vId_d  = 1'b0;
                vEx1_d = 1'b0;
                vEx2_d = 1'b0;
            end
            WIN_EX1: begin
                vId_d  = 1'b0;
                vEx1_d = 1'b0;
            end
            WIN_STALL: begin
                vId_d  = vId_q;
                vEx1_d = 1'b0;
            end
            WIN_ID:  vId_d = 1'b0;
            default: vId_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vId_q  <= 1'b0;
            vEx1_q <= 1'b0;
            vEx2_q <= 1'b0;
        end else begin
            vId_q  <= vId_d;
            vEx1_q <= vEx1_d;
            vEx2_q <= vEx2_d;
        end
    end

    assign ID_valid  = vId_q;
    assign EX1_valid = vEx1_q;
    assign EX2_valid = vEx2_q;

`ifdef REDIRECT_STATS_EN
    logic [CNT_W-1:0] redirCnt_q, redirCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    // Redirects count even when a stall wins; stalls count only when they win.
    always_comb begin
        redirCnt_d = redirCnt_q;
        stallCnt_d = stallCnt_q;
        if ((effEx2 | effEx1 | effId) && (redirCnt_q != {CNT_W{1'b1}}))
            redirCnt_d = redirCnt_q + 1'b1;
        if ((winner == WIN_STALL) && (stallCnt_q != {CNT_W{1'b1}}))
            stallCnt_d = stallCnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirCnt_q <= '0;
            stallCnt_q <= '0;
        end else begin
            redirCnt_q <= redirCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign redir_cnt = redirCnt_q;
    assign stall_cnt = stallCnt_q;
`else
    // CNT_W only sizes the statistics counters, which are absent in this build.
    if (CNT_W > 0) begin : g_no_stats
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Randomized self-checking bench for fetch_redirect_ctrl against a stage-occupancy model.
// Counter checks are compiled in only when REDIRECT_STATS_EN is defined.
module tb_fetch_redirect_ctrl;

    logic        clk;
    logic        rst;
    logic        ID_redir, EX1_redir, EX2_redir, hazard_stall;
    logic [2:0]  PC_src;
    logic        PC_write, IF_ID_flush, ID_EX1_flush, EX1_EX2_flush;
    logic        ID_valid, EX1_valid, EX2_valid;
`ifdef REDIRECT_STATS_EN
    logic [31:0] redir_cnt, stall_cnt;
`endif

    int          assertCount = 0;
    int          failCount   = 0;

    // Model state: occupancy of ID, EX1, EX2 (index 0..2) and event counts.
    logic        mV [3];
    longint      mRedir, mStall;

    fetch_redirect_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_redir     (ID_redir),
        .EX1_redir    (EX1_redir),
        .EX2_redir    (EX2_redir),
        .hazard_stall (hazard_stall),
        .PC_src       (PC_src),
        .PC_write     (PC_write),
        .IF_ID_flush  (IF_ID_flush),
        .ID_EX1_flush (ID_EX1_flush),
        .EX1_EX2_flush(EX1_EX2_flush),
        .ID_valid     (ID_valid),
        .EX1_valid    (EX1_valid),
        .EX2_valid    (EX2_valid)
`ifdef REDIRECT_STATS_EN
        ,
        .redir_cnt    (redir_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) mV[i] = 1'b0;
        mRedir = 0;
        mStall = 0;
    endtask

    task automatic checkValids(input string tag);
        checkOutput({tag, "_vid"},  ID_valid,  mV[0]);
        checkOutput({tag, "_vex1"}, EX1_valid, mV[1]);
        checkOutput({tag, "_vex2"}, EX2_valid, mV[2]);
`ifdef REDIRECT_STATS_EN
        checkOutput({tag, "_rcnt"}, redir_cnt, mRedir);
        checkOutput({tag, "_scnt"}, stall_cnt, mStall);
`endif
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_src"},  PC_src,        0);
        checkOutput({tag, "_wr"},   PC_write,      0);
        checkOutput({tag, "_f0"},   IF_ID_flush,   0);
        checkOutput({tag, "_f1"},   ID_EX1_flush,  0);
        checkOutput({tag, "_f2"},   EX1_EX2_flush, 0);
        checkValids(tag);
    endtask

    // Called ~1ns after a rising edge: drive, check outputs, clock, check state.
    task automatic applyStimulus(input logic idR, input logic ex1R, input logic ex2R,
                                 input logic hz);
        int   killDepth;
        bit   stallWins;
        int   expSrc;
        logic nxt [3];
        ID_redir     = idR;
        EX1_redir    = ex1R;
        EX2_redir    = ex2R;
        hazard_stall = hz;
        #1;
        killDepth = 0;
        stallWins = 0;
        expSrc    = 0;
        if (ex2R && mV[2]) begin
            killDepth = 3; expSrc = 4;
        end else if (ex1R && mV[1]) begin
            killDepth = 2; expSrc = 3;
        end else if (hz && mV[0]) begin
            stallWins = 1; expSrc = 2;
        end else if (idR && mV[0]) begin
            killDepth = 1; expSrc = 1;
        end
        checkOutput("pc_src",    PC_src,        expSrc);
        checkOutput("pc_write",  PC_write,      !stallWins);
        checkOutput("ifid_fl",   IF_ID_flush,   killDepth >= 1);
        checkOutput("idex1_fl",  ID_EX1_flush,  (killDepth >= 2) || stallWins);
        checkOutput("ex1ex2_fl", EX1_EX2_flush, killDepth >= 3);

        nxt[0] = 1'b1;
        nxt[1] = mV[0];
        nxt[2] = mV[1];
        for (int i = 0; i < 3; i++)
            if (i < killDepth) nxt[i] = 1'b0;
        if (stallWins) begin
            nxt[0] = mV[0];
            nxt[1] = 1'b0;
        end
        if ((ex2R && mV[2]) || (ex1R && mV[1]) || (idR && mV[0])) mRedir++;
        if (stallWins) mStall++;

        @(posedge clk);
        for (int i = 0; i < 3; i++) mV[i] = nxt[i];
        #1;
        checkValids("step");
    endtask

    task automatic randomInputs();
        ID_redir     = ($urandom_range(3) == 0);
        EX1_redir    = ($urandom_range(3) == 0);
        EX2_redir    = ($urandom_range(3) == 0);
        hazard_stall = ($urandom_range(3) == 0);
    endtask

    initial begin
        rst = 1'b0;
        modelReset();
        ID_redir = 1'b0; EX1_redir = 1'b0; EX2_redir = 1'b0; hazard_stall = 1'b0;

        // Held in reset for two cycles with arbitrary requests present.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            randomInputs();
            #1;
            checkQuiet("in_reset");
        end
        rst = 1'b1;

        // Idle fill: valids come up one stage per cycle.
        applyStimulus(0, 0, 0, 0);
        checkOutput("fill_id1", ID_valid, 1);
        checkOutput("fill_ex1", EX1_valid, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("fill_ex2", EX2_valid, 1);

        // ID redirect, then two stall cycles, then fill again.
        applyStimulus(1, 0, 0, 0);
        checkOutput("idr_vid", ID_valid, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("stall_vid", ID_valid, 1);
        checkOutput("stall_vex1", EX1_valid, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Everything at once: EX2 wins, then a shadowed EX1 request is ignored.
        applyStimulus(1, 1, 1, 1);
        checkOutput("ex2_clear", {ID_valid, EX1_valid, EX2_valid}, 0);
        applyStimulus(0, 1, 0, 0);

        // EX1 redirect followed by an ID request from the squashed slot.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("ex1_shadow_vex2", EX2_valid, 0);

        // Randomized traffic with occasional asynchronous reset mid-cycle.
        for (int n = 0; n < 400; n++) begin
            if ((n % 67) == 66) begin
                randomInputs();
                #2;
                rst = 1'b0;
                modelReset();
                #1;
                checkQuiet("async_rst");
                @(posedge clk);
                #1;
                checkQuiet("async_rst_hold");
                rst = 1'b1;
            end
            applyStimulus($urandom_range(3) == 0, $urandom_range(3) == 0,
                          $urandom_range(4) == 0, $urandom_range(3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Control sequencer for the instruction-fetch stage.
- Arbitrates redirect requests from ID, EX1 and EX2 plus the load-use stall, and drives the fetch PC source-select mux (PC_src) and PC_write.
- Tracks per-stage valid bits so that redirects and stalls from squashed (wrong-path) instructions are ignored.
- Emits the pipeline-register flush strobes for IF/ID, ID/EX1 and EX1/EX2.

Parameters:
- CNT_W, 32, width of the statistics counters (used only when REDIRECT_STATS_EN is defined).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- ID_redir  input  1  ID-stage jump/predicted-taken redirect request (target is ID_PFC).
- EX1_redir  input  1  EX1 mispredict/redirect request (target is EX1_PFC).
- EX2_redir  input  1  EX2 mispredict/redirect request (target is EX2_PFC).
- hazard_stall  input  1  load-use hazard detected for the instruction in ID.
- PC_src  output  3  fetch mux select: 0=PC+1, 1=ID_PFC, 2=PC hold, 3=EX1_PFC, 4=EX2_PFC; 5-7 are never driven.
- PC_write  output  1  PC register write enable.
- IF_ID_flush  output  1  squash the IF/ID register.
- ID_EX1_flush  output  1  insert a bubble into ID/EX1.
- EX1_EX2_flush  output  1  squash EX1/EX2.
- ID_valid, EX1_valid, EX2_valid  output  1 each  registered stage-valid bits (debug/verification visibility).

Behaviour:
- Reset (rst=0, asynchronous): v_id=v_ex1=v_ex2=0. While in reset, PC_write=0, PC_src=0 and all flush outputs are 0.
- Effective requests are combinational:
  - e2 = EX2_redir & v_ex2
  - e1 = EX1_redir & v_ex1
  - st = hazard_stall & v_id
  - e0 = ID_redir & v_id
- Fixed priority, resolved in the same cycle (zero latency to PC_src): e2 > e1 > st > e0 > sequential.
  - e2: PC_src=4, PC_write=1, IF_ID_flush=1, ID_EX1_flush=1, EX1_EX2_flush=1.
  - e1: PC_src=3, PC_write=1, IF_ID_flush=1, ID_EX1_flush=1.
  - st: PC_src=2, PC_write=0, ID_EX1_flush=1 (bubble). IF/ID holds: the instruction stays in ID.
  - e0: PC_src=1, PC_write=1, IF_ID_flush=1.
  - none: PC_src=0, PC_write=1, no flush.
- Flush outputs not listed for a case are 0.
- Valid-bit update on the rising clock edge:
  - e2: v_id<=0, v_ex1<=0, v_ex2<=0.
  - e1: v_id<=0, v_ex1<=0, v_ex2<=v_ex1 (the branch itself proceeds).
  - st: v_id holds, v_ex1<=0, v_ex2<=v_ex1.
  - e0: v_id<=0, v_ex1<=v_id, v_ex2<=v_ex1.
  - none: v_id<=1, v_ex1<=v_id, v_ex2<=v_ex1.
- First cycle after reset release: v_id=0, so ID requests are ignored and the pipeline fills over 3 cycles.
- Simultaneous events resolve strictly by priority. Example: an e1 during st cancels the stall (PC_write=1) and squashes the stalled ID instruction.
- A redirect from a stage whose valid bit is 0 has no effect on any output.
- Reset asserted mid-redirect clears all valid bits immediately; no partial flush persists.
- No combinational path exists from any output back to any input.

Optional Feature:
- Macro: REDIRECT_STATS_EN.
- Defined:
  - Adds outputs redir_cnt[CNT_W-1:0] and stall_cnt[CNT_W-1:0].
  - redir_cnt increments on any cycle with e2|e1|e0.
  - stall_cnt increments on a cycle where st wins arbitration.
  - Both counters saturate at all-ones and reset to 0 asynchronously with rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: rst low 2 cycles, release, no requests -> PC_src=0, PC_write=1 every cycle; valid bits become ID=1 at cycle 1, EX1=1 at 2, EX2=1 at 3.
- ID redirect with pipeline full: ID_redir=1 for one cycle -> PC_src=1, IF_ID_flush=1; next cycle ID_valid=0, EX1_valid=1.
- Stall: hazard_stall=1 for 2 cycles with ID_valid=1 -> PC_src=2, PC_write=0, ID_EX1_flush=1 both cycles; ID_valid stays 1, EX1_valid=0 after the first edge.
- EX2 mispredict beats the others: EX2_redir=EX1_redir=ID_redir=hazard_stall=1, all valid -> PC_src=4, all three flushes=1; next cycle all valids=0; a following EX1_redir=1 is ignored (PC_src=0).
- EX1 redirect then shadow: EX1_redir=1 -> PC_src=3; next cycle ID_redir=1 is ignored (ID_valid=0) -> PC_src=0; EX2_valid=1.
- With REDIRECT_STATS_EN: 3 redirects + 2 stall cycles -> redir_cnt=3, stall_cnt=2. With CNT_W=2 and 5 redirects -> redir_cnt saturates at 3.
